// File: rtl/i2c_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_ram_pkg
// Description : Shared types and constants for the I2C register-RAM arbiter
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_ram_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 8;

    // Requester identifiers latched at grant time
    localparam logic REQ_I2C  = 1'b0;
    localparam logic REQ_MENU = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2,
        ST_CLEAR  = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/i2c_ram_clear_seq.sv
`default_nettype none
// ============================================================================
// Module      : i2c_ram_clear_seq
// Description : Address sweep for a full-RAM clear; one word per cycle,
//               busy for exactly DEPTH cycles, done pulse afterwards
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_ram_clear_seq #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    output logic              busy_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o,
    output logic              done_o
);

    logic              busy_q;
    logic [ADDR_W-1:0] addr_q;
    logic              done_q;
    logic              w_last;

    assign w_last = busy_q && (addr_q == ADDR_W'(DEPTH - 1));

    // Sweep counter: start loads word 0, the last word ends the sweep and fires done
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= 1'b0;
            addr_q <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (busy_q) begin
                if (w_last) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end else begin
                    addr_q <= addr_q + 1'b1;
                end
            end else if (start_i) begin
                busy_q <= 1'b1;
                addr_q <= '0;
            end
        end
    end

    assign busy_o = busy_q;
    assign addr_o = addr_q;
    assign last_o = w_last;
    assign done_o = done_q;

endmodule
`default_nettype wire

// File: rtl/i2c_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : i2c_ram_arbiter
// Description : Request/acknowledge arbiter sharing one single-port RAM
//               between the I2C engine, the menu controller and a clear sweep
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_ram_arbiter
    import i2c_ram_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int DEPTH       = 32,
    parameter int MAX_I2C_RUN = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i2c_req,
    input  logic              i2c_we,
    input  logic [ADDR_W-1:0] i2c_addr,
    input  logic [DATA_W-1:0] i2c_wdata,
    output logic              i2c_ack,
    output logic [DATA_W-1:0] i2c_rdata,
    input  logic              menu_req,
    input  logic              menu_we,
    input  logic [ADDR_W-1:0] menu_addr,
    input  logic [DATA_W-1:0] menu_wdata,
    output logic              menu_ack,
    output logic [DATA_W-1:0] menu_rdata,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam int RUN_W = $clog2(MAX_I2C_RUN + 1);

    state_e            state_q;
    logic              win_q;
    logic              win_we_q;
    logic [RUN_W-1:0]  run_q;
    logic              pend_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_din_q;
    logic              ram_we_q;
    logic              i2c_ack_q;
    logic              menu_ack_q;
    logic [DATA_W-1:0] i2c_rdata_q;
    logic [DATA_W-1:0] menu_rdata_q;

    logic              w_clr_pend;
    logic              w_menu_first;
    logic              w_clr_start;
    logic              w_seq_last;
    logic [ADDR_W-1:0] w_seq_addr;
    logic              w_in_clear;
    logic              w_rd_resp;

    // A clear request arriving this very cycle counts as pending so it beats a client
    assign w_clr_pend   = pend_q | clr_req;
    assign w_menu_first = menu_req && (run_q == RUN_W'(MAX_I2C_RUN));
    assign w_clr_start  = (state_q == ST_IDLE) && w_clr_pend;
    assign w_in_clear   = (state_q == ST_CLEAR);
    assign w_rd_resp    = (state_q == ST_RESP) && !win_we_q;

    i2c_ram_clear_seq #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_clear_seq (
        .clk     (clk),
        .reset   (reset),
        .start_i (w_clr_start),
        .busy_o  (clr_busy),
        .addr_o  (w_seq_addr),
        .last_o  (w_seq_last),
        .done_o  (clr_done)
    );

    // Arbitration FSM with registered RAM strobes, acks and read-data holding registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            win_q        <= REQ_I2C;
            win_we_q     <= 1'b0;
            run_q        <= '0;
            pend_q       <= 1'b0;
            ram_addr_q   <= '0;
            ram_din_q    <= '0;
            ram_we_q     <= 1'b0;
            i2c_ack_q    <= 1'b0;
            menu_ack_q   <= 1'b0;
            i2c_rdata_q  <= '0;
            menu_rdata_q <= '0;
        end else begin
            i2c_ack_q  <= 1'b0;
            menu_ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!menu_req) begin
                        run_q <= '0;
                    end
                    if (w_clr_pend) begin
                        pend_q  <= 1'b0;
                        state_q <= ST_CLEAR;
                    end else if (w_menu_first || (menu_req && !i2c_req)) begin
                        win_q      <= REQ_MENU;
                        win_we_q   <= menu_we;
                        ram_addr_q <= menu_addr;
                        ram_din_q  <= menu_wdata;
                        ram_we_q   <= menu_we;
                        run_q      <= '0;
                        state_q    <= ST_ACCESS;
                    end else if (i2c_req) begin
                        win_q      <= REQ_I2C;
                        win_we_q   <= i2c_we;
                        ram_addr_q <= i2c_addr;
                        ram_din_q  <= i2c_wdata;
                        ram_we_q   <= i2c_we;
                        if (menu_req && (run_q != RUN_W'(MAX_I2C_RUN))) begin
                            run_q <= run_q + 1'b1;
                        end
                        state_q    <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    ram_we_q <= 1'b0;
                    pend_q   <= w_clr_pend;
                    if (win_q == REQ_I2C) begin
                        i2c_ack_q <= 1'b1;
                    end else begin
                        menu_ack_q <= 1'b1;
                    end
                    state_q  <= ST_RESP;
                end
                ST_RESP: begin
                    pend_q <= w_clr_pend;
                    if (!win_we_q) begin
                        if (win_q == REQ_I2C) begin
                            i2c_rdata_q <= ram_dout;
                        end else begin
                            menu_rdata_q <= ram_dout;
                        end
                    end
                    state_q <= ST_IDLE;
                end
                ST_CLEAR: begin
                    // Leave the RAM port parked on the last swept word
                    if (w_seq_last) begin
                        ram_addr_q <= w_seq_addr;
                        ram_din_q  <= '0;
                        state_q    <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // RAM read data lands during RESP, so the ack cycle forwards it before it is held
    assign i2c_rdata  = (w_rd_resp && (win_q == REQ_I2C))  ? ram_dout : i2c_rdata_q;
    assign menu_rdata = (w_rd_resp && (win_q == REQ_MENU)) ? ram_dout : menu_rdata_q;
    assign i2c_ack    = i2c_ack_q;
    assign menu_ack   = menu_ack_q;

    assign ram_addr = w_in_clear ? w_seq_addr : ram_addr_q;
    assign ram_din  = w_in_clear ? '0         : ram_din_q;
    assign ram_we   = w_in_clear | ram_we_q;

endmodule
`default_nettype wire

// File: doc/i2c_ram_arbiter.md
Name: i2c_ram_arbiter

Overview:
Shares one single-port synchronous 32x8 register RAM between three clients: the I2C slave byte engine, the LCD menu controller, and a clear sequencer. It sits between those clients and the RAM in the I2C slave top level. It replaces the direct RemoteRAM/LocalRAM/MultiRAM wiring with a request/acknowledge scheme. It guarantees one RAM access per grant and bounded wait for the menu side.

Parameters:
ADDR_W, 5, RAM address width
DATA_W, 8, RAM data width
DEPTH, 32, words swept by a clear; must equal 2**ADDR_W
MAX_I2C_RUN, 4, consecutive I2C grants allowed while a menu request is pending

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
i2c_req  in  1  I2C access request; held with fields stable until i2c_ack
i2c_we  in  1  1=write, 0=read
i2c_addr  in  ADDR_W  I2C access address
i2c_wdata  in  DATA_W  I2C write data
i2c_ack  out  1  one-cycle completion pulse
i2c_rdata  out  DATA_W  read data; valid in the i2c_ack cycle and held until the next I2C ack
menu_req, menu_we, menu_addr, menu_wdata  in  1/1/ADDR_W/DATA_W  menu port, same rules as I2C
menu_ack  out  1  menu completion pulse
menu_rdata  out  DATA_W  menu read data; same rules as I2C
clr_req  in  1  pulse: zero the whole RAM
clr_busy  out  1  high while the sweep runs
clr_done  out  1  one-cycle pulse after the last word is written
ram_addr  out  ADDR_W  RAM address
ram_din  out  DATA_W  RAM write data
ram_we  out  1  RAM write strobe
ram_dout  in  DATA_W  RAM read data, valid one cycle after the address is presented

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; run counter 0; pending-clear flag 0. Reset mid-sweep aborts the sweep; RAM contents are left partially cleared.
- FSM states: IDLE, ACCESS, RESP, CLEAR.
- IDLE arbitration, in priority order:
  - pending clear first.
  - menu, if menu_req=1 and run counter = MAX_I2C_RUN.
  - i2c.
  - menu.
  - Winner is latched, then go to ACCESS. No request: stay in IDLE.
- ACCESS (1 cycle): drive ram_addr/ram_din from the winner; ram_we=winner's we. Go to RESP.
- RESP (1 cycle):
  - Pulse the winner's ack.
  - On a read, capture ram_dout into the winner's rdata.
  - On a write, rdata is unchanged.
  - Go to IDLE.
- Turnaround: request seen in cycle T gives ack in T+2; the next grant is earliest at T+3. A requester deasserts or changes its request in the cycle after ack.
- Run counter:
  - +1 on each I2C grant made while menu_req=1, saturating at MAX_I2C_RUN.
  - Cleared on a menu grant, or when menu_req=0 in IDLE.
- Clear:
  - clr_req sets the pending flag in any state. An in-flight access completes first.
  - CLEAR: ram_we=1, ram_din=0, ram_addr steps 0..DEPTH-1, one word per cycle. clr_busy=1 for exactly DEPTH cycles.
  - After the sweep, clr_done pulses one cycle, in IDLE. Pending flag clears on CLEAR entry.
  - clr_req during CLEAR is ignored. Client requests wait; they are not acked during CLEAR.
- Simultaneous events:
  - clr_req with i2c_req in IDLE: clear wins.
  - i2c and menu in the same cycle: i2c wins unless the run counter is saturated.
- ram_we is 0 in every state except ACCESS-write and CLEAR. ram_addr and ram_din hold their last values otherwise.
- No address range check is needed: ADDR_W covers DEPTH exactly.

Decomposition:
- Shared package i2c_ram_pkg:
  - state enum (IDLE/ACCESS/RESP/CLEAR).
  - requester ID constants (REQ_I2C=0, REQ_MENU=1).
  - ADDR_W/DATA_W defaults.
- One sub-module, i2c_ram_clear_seq: address counter, clr_busy, last-word detect and clr_done. It is started by the arbiter FSM.

Test Plan:
- I2C write 0xA5 to addr 3, then I2C read addr 3 -> first i2c_ack at T+2 with ram_we=1 at T+1; read ack returns i2c_rdata=0xA5.
- i2c_req and menu_req both held continuously, MAX_I2C_RUN=4 -> grant order I,I,I,I,M,I,I,I,I,M…; each ack 3 cycles apart.
- Preload addrs 0..31 with 0xFF; pulse clr_req -> clr_busy high for exactly 32 cycles, addresses 0..31 each written with 0; clr_done one cycle; subsequent menu reads return 0x00.
- clr_req in the same cycle as i2c_req in IDLE, and clr_req during ACCESS -> clear runs first; in-flight access acks before CLEAR; the queued I2C is acked only after clr_done.
- Assert reset at sweep word 10 -> all outputs 0 immediately (async); after release, state IDLE, no clr_done, words 10..31 unchanged.
- Menu read of addr 31 while I2C is idle, then I2C read -> menu_rdata holds its value through the I2C ack; i2c_rdata is unchanged by the menu transaction.
